// File: rtl/systolic_tile_ctrl.sv
// Job controller for a SIZE x SIZE systolic MAC array: load, skewed MAC, flush, row output.
// Optional SYSTOLIC_CTRL_PERF_EN adds perf_cycles / job_cnt counter ports.
module systolic_tile_ctrl #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic [31:0]             perf_cycles,
  output logic [15:0]             job_cnt,
`endif
  input  logic [CW-1:0]           cfg_k,
  input  logic                    x_send_val,
  output logic                    x_send_rdy,
  input  logic                    w_send_val,
  output logic                    w_send_rdy,
  input  logic [SIZE-1:0]         x_fifo_full,
  input  logic [SIZE-1:0]         x_fifo_empty,
  output logic [SIZE-1:0]         x_fifo_wen,
  output logic [SIZE-1:0]         x_fifo_ren,
  input  logic [SIZE-1:0]         w_fifo_full,
  input  logic [SIZE-1:0]         w_fifo_empty,
  output logic [SIZE-1:0]         w_fifo_wen,
  output logic [SIZE-1:0]         w_fifo_ren,
  output logic                    mac_en,
  output logic                    acc_clr,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [$clog2(SIZE)-1:0] out_row,
  output logic                    err
);

  localparam int RW  = $clog2(SIZE);
  localparam int CTW = $clog2(DEPTH + SIZE + 1);

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_FLUSH, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   x_cnt_q, x_cnt_d;
  logic [CW-1:0]   w_cnt_q, w_cnt_d;
  logic [CTW-1:0]  c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic            err_q, err_d;

  logic            x_rdy_c, w_rdy_c, x_acc, w_acc;
  logic            ren_on, mac_on, out_on, acc_clr_c;
  logic [SIZE-1:0] win, ren_c;
  logic [CTW-1:0]  k_ext;

  function automatic logic [CW-1:0] clamp_k(input logic [CW-1:0] k);
    if (k == '0)
      return CW'(1);
    else if (k > CW'(DEPTH))
      return CW'(DEPTH);
    else
      return k;
  endfunction

  assign k_ext = CTW'(k_q);

  // Row gi reads during c in [gi, gi+k-1], giving the one-cycle skew between rows.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_win
      assign win[gi] = (c_q >= CTW'(gi)) && (c_q <= CTW'(gi) + k_ext - CTW'(1));
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_cnt_d   = x_cnt_q;
    w_cnt_d   = w_cnt_q;
    c_d       = c_q;
    r_d       = r_q;
    x_rdy_c   = 1'b0;
    w_rdy_c   = 1'b0;
    x_acc     = 1'b0;
    w_acc     = 1'b0;
    ren_on    = 1'b0;
    mac_on    = 1'b0;
    out_on    = 1'b0;
    acc_clr_c = 1'b0;
    case (state_q)
      S_LOAD: begin
        x_rdy_c = (x_cnt_q < k_q) && !(|x_fifo_full);
        w_rdy_c = (w_cnt_q < k_q) && !(|w_fifo_full);
        x_acc   = x_send_val && x_rdy_c;
        w_acc   = w_send_val && w_rdy_c;
        if (x_acc) x_cnt_d = x_cnt_q + CW'(1);
        if (w_acc) w_cnt_d = w_cnt_q + CW'(1);
        // Looking at the next counts lets MAC start right after the last accept.
        if (x_cnt_d == k_q && w_cnt_d == k_q) begin
          state_d = S_MAC;
          c_d     = '0;
        end
      end
      S_MAC: begin
        ren_on = 1'b1;
        mac_on = 1'b1;
        if (c_q == k_ext + CTW'(SIZE - 2)) begin
          state_d = S_FLUSH;
          c_d     = '0;
        end else begin
          c_d = c_q + CTW'(1);
        end
      end
      S_FLUSH: begin
        mac_on = 1'b1;
        if (c_q == CTW'(SIZE - 1)) begin
          state_d = S_OUT;
          r_d     = '0;
        end else begin
          c_d = c_q + CTW'(1);
        end
      end
      S_OUT: begin
        out_on = 1'b1;
        if (out_rdy) begin
          if (r_q == RW'(SIZE - 1)) begin
            acc_clr_c = 1'b1;
            state_d   = S_LOAD;
            x_cnt_d   = '0;
            w_cnt_d   = '0;
            r_d       = '0;
            k_d       = clamp_k(cfg_k);
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    ren_c = ren_on ? win : '0;
    err_d = err_q | (|(ren_c & x_fifo_empty)) | (|(ren_c & w_fifo_empty));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_LOAD;
      k_q     <= clamp_k(cfg_k);
      x_cnt_q <= '0;
      w_cnt_q <= '0;
      c_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_cnt_q <= x_cnt_d;
      w_cnt_q <= w_cnt_d;
      c_q     <= c_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  // All outputs are forced low while reset is asserted.
  assign x_send_rdy = rst & x_rdy_c;
  assign w_send_rdy = rst & w_rdy_c;
  assign x_fifo_wen = {SIZE{rst & x_acc}};
  assign w_fifo_wen = {SIZE{rst & w_acc}};
  assign x_fifo_ren = rst ? ren_c : '0;
  assign w_fifo_ren = rst ? ren_c : '0;
  assign mac_en     = rst & mac_on;
  assign acc_clr    = rst & acc_clr_c;
  assign out_val    = rst & out_on;
  assign out_row    = rst ? r_q : '0;
  assign err        = rst & err_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic [15:0] job_q, job_d;

  always_comb begin
    perf_d = perf_q;
    job_d  = job_q;
    if (mac_on && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    if (acc_clr_c) job_d = job_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_q <= '0;
      job_q  <= '0;
    end else begin
      perf_q <= perf_d;
      job_q  <= job_d;
    end
  end

  assign perf_cycles = rst ? perf_q : '0;
  assign job_cnt     = rst ? job_q : '0;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed testbench for systolic_tile_ctrl (SIZE=4, DEPTH=8).
module tb_systolic_tile_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cfg_k;
  logic       x_send_val, x_send_rdy, w_send_val, w_send_rdy;
  logic [3:0] x_fifo_full, x_fifo_empty, x_fifo_wen, x_fifo_ren;
  logic [3:0] w_fifo_full, w_fifo_empty, w_fifo_wen, w_fifo_ren;
  logic       mac_en, acc_clr, out_val, out_rdy, err;
  logic [1:0] out_row;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] job_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  systolic_tile_ctrl #(.SIZE(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
`ifdef SYSTOLIC_CTRL_PERF_EN
    .perf_cycles(perf_cycles), .job_cnt(job_cnt),
`endif
    .cfg_k(cfg_k),
    .x_send_val(x_send_val), .x_send_rdy(x_send_rdy),
    .w_send_val(w_send_val), .w_send_rdy(w_send_rdy),
    .x_fifo_full(x_fifo_full), .x_fifo_empty(x_fifo_empty),
    .x_fifo_wen(x_fifo_wen), .x_fifo_ren(x_fifo_ren),
    .w_fifo_full(w_fifo_full), .w_fifo_empty(w_fifo_empty),
    .w_fifo_wen(w_fifo_wen), .w_fifo_ren(w_fifo_ren),
    .mac_en(mac_en), .acc_clr(acc_clr),
    .out_val(out_val), .out_rdy(out_rdy), .out_row(out_row), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [23:0] v;
    rst = 1'b0; cfg_k = 4'd3; x_send_val = 1'b1; w_send_val = 1'b1; out_rdy = 1'b1;
    repeat (3) tick();
    v = {x_send_rdy, w_send_rdy, x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren,
         mac_en, acc_clr, out_val, out_row, err};
    checks++;
    if (v !== 24'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", v, 24'd0); end
    x_send_val = 1'b0; w_send_val = 1'b0; out_rdy = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (x_send_rdy !== 1'b1) begin failures++; $display("FAIL reset_release_rdy got=%b exp=1", x_send_rdy); end
    $display("reset done");
  endtask

  task automatic test_basic_k3;
    logic [3:0] ren3 [6];
    ren3 = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    x_send_val = 1'b1; w_send_val = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if ({x_send_rdy, w_send_rdy, x_fifo_wen, w_fifo_wen} !== 10'h3FF) begin
        failures++; $display("FAIL k3_load%0d got=%b exp=%b", n, {x_send_rdy, w_send_rdy, x_fifo_wen, w_fifo_wen}, 10'h3FF);
      end
      $display("k3 load vector %0d", n);
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (x_fifo_ren !== ren3[c] || w_fifo_ren !== ren3[c]) begin
        failures++; $display("FAIL k3_ren_c%0d got x=%b w=%b exp=%b", c, x_fifo_ren, w_fifo_ren, ren3[c]);
      end
      checks++;
      if ({mac_en, x_send_rdy, x_fifo_wen} !== 6'b100000) begin
        failures++; $display("FAIL k3_mac_c%0d got=%b exp=100000", c, {mac_en, x_send_rdy, x_fifo_wen});
      end
      tick();
    end
    x_send_val = 1'b0; w_send_val = 1'b0;
    for (int f = 0; f < 4; f++) begin
      #1;
      checks++;
      if ({mac_en, x_fifo_ren, w_fifo_ren, out_val} !== 10'b1000000000) begin
        failures++; $display("FAIL k3_flush%0d got=%b exp=1000000000", f, {mac_en, x_fifo_ren, w_fifo_ren, out_val});
      end
      tick();
    end
    out_rdy = 1'b1; cfg_k = 4'd2;
    for (int r = 0; r < 4; r++) begin
      #1;
      checks++;
      if (out_val !== 1'b1 || out_row !== 2'(r) || acc_clr !== (r == 3)) begin
        failures++; $display("FAIL k3_out%0d got val=%b row=%0d clr=%b exp val=1 row=%0d clr=%b",
                             r, out_val, out_row, acc_clr, r, (r == 3));
      end
      $display("k3 row %0d accepted", r);
      tick();
    end
    out_rdy = 1'b0;
    #1;
    checks++;
    if ({out_val, mac_en, x_send_rdy, err} !== 4'b0010) begin
      failures++; $display("FAIL k3_back_to_load got=%b exp=0010", {out_val, mac_en, x_send_rdy, err});
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    checks++;
    if (perf_cycles !== 32'd10 || job_cnt !== 16'd1) begin
      failures++; $display("FAIL k3_perf got cyc=%0d jobs=%0d exp cyc=10 jobs=1", perf_cycles, job_cnt);
    end
`endif
  endtask

  task automatic test_uneven_k2;
    logic [3:0] ren2 [5];
    ren2 = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
    for (int n = 0; n < 3; n++) begin
      x_send_val = 1'b1; w_send_val = (n % 2 == 0);
      #1;
      checks++;
      if (x_send_rdy !== (n < 2) || w_send_rdy !== 1'b1 || mac_en !== 1'b0) begin
        failures++; $display("FAIL k2_load%0d got xr=%b wr=%b mac=%b exp xr=%b wr=1 mac=0",
                             n, x_send_rdy, w_send_rdy, mac_en, (n < 2));
      end
      $display("k2 load cycle %0d x_acc=%b w_acc=%b", n, x_send_rdy, w_send_val);
      tick();
    end
    x_send_val = 1'b0; w_send_val = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (mac_en !== 1'b1 || x_fifo_ren !== ren2[c] || w_fifo_ren !== ren2[c]) begin
        failures++; $display("FAIL k2_mac_c%0d got mac=%b x=%b w=%b exp mac=1 ren=%b",
                             c, mac_en, x_fifo_ren, w_fifo_ren, ren2[c]);
      end
      tick();
    end
    repeat (3) tick();
    #1;
    checks++;
    if (out_val !== 1'b0 || mac_en !== 1'b1) begin
      failures++; $display("FAIL k2_last_flush got val=%b mac=%b exp val=0 mac=1", out_val, mac_en);
    end
    tick();
    checks++;
    if (out_val !== 1'b1 || out_row !== 2'd0 || mac_en !== 1'b0) begin
      failures++; $display("FAIL k2_first_out got val=%b row=%0d mac=%b exp val=1 row=0 mac=0", out_val, out_row, mac_en);
    end
  endtask

  task automatic test_backpressure;
    int  exp_r;
    logic done;
    exp_r = 0; done = 1'b0; cfg_k = 4'd0;
    for (int n = 0; n < 20 && !done; n++) begin
      out_rdy = (n % 3 == 0);
      #1;
      checks++;
      if (out_val !== 1'b1 || out_row !== 2'(exp_r) || acc_clr !== (out_rdy && exp_r == 3)) begin
        failures++; $display("FAIL bp_cycle%0d got val=%b row=%0d clr=%b exp val=1 row=%0d clr=%b",
                             n, out_val, out_row, acc_clr, exp_r, (out_rdy && exp_r == 3));
      end
      if (out_rdy) begin
        $display("bp row %0d accepted at cycle %0d", exp_r, n);
        if (exp_r == 3) done = 1'b1;
        else exp_r++;
      end
      tick();
    end
    checks++;
    if (!done) begin failures++; $display("FAIL bp_timeout got rows=%0d exp rows=4", exp_r); end
    out_rdy = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b0 || x_send_rdy !== 1'b1) begin
      failures++; $display("FAIL bp_next_load got val=%b rdy=%b exp val=0 rdy=1", out_val, x_send_rdy);
    end
  endtask

  task automatic test_k0;
    logic [3:0] ren1 [4];
    ren1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    x_send_val = 1'b1; w_send_val = 1'b1;
    #1;
    checks++;
    if (x_send_rdy !== 1'b1 || w_send_rdy !== 1'b1) begin
      failures++; $display("FAIL k0_load got xr=%b wr=%b exp 1 1", x_send_rdy, w_send_rdy);
    end
    $display("k0 single vector loaded");
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (x_fifo_ren !== ren1[c] || w_fifo_ren !== ren1[c] || x_send_rdy !== 1'b0) begin
        failures++; $display("FAIL k0_mac_c%0d got x=%b w=%b rdy=%b exp ren=%b rdy=0",
                             c, x_fifo_ren, w_fifo_ren, x_send_rdy, ren1[c]);
      end
      tick();
    end
    x_send_val = 1'b0; w_send_val = 1'b0;
    for (int f = 0; f < 4; f++) begin
      #1;
      checks++;
      if (mac_en !== 1'b1 || x_fifo_ren !== 4'b0000 || out_val !== 1'b0) begin
        failures++; $display("FAIL k0_flush%0d got mac=%b ren=%b val=%b exp 1 0000 0", f, mac_en, x_fifo_ren, out_val);
      end
      tick();
    end
    cfg_k = 4'd15; out_rdy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      #1;
      checks++;
      if (out_val !== 1'b1 || out_row !== 2'(r)) begin
        failures++; $display("FAIL k0_out%0d got val=%b row=%0d exp val=1 row=%0d", r, out_val, out_row, r);
      end
      $display("k0 row %0d accepted", r);
      tick();
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_k15_clamp_err;
    x_send_val = 1'b1; w_send_val = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      checks++;
      if (x_send_rdy !== (n < 8) || w_send_rdy !== (n < 8) || mac_en !== (n >= 8)) begin
        failures++; $display("FAIL k15_cycle%0d got xr=%b wr=%b mac=%b exp xr=%b wr=%b mac=%b",
                             n, x_send_rdy, w_send_rdy, mac_en, (n < 8), (n < 8), (n >= 8));
      end
      if (n < 8) $display("k15 load vector %0d", n);
      tick();
    end
    x_send_val = 1'b0; w_send_val = 1'b0;
    x_fifo_empty = 4'b0100;
    #1;
    checks++;
    if (x_fifo_ren !== 4'b0111 || err !== 1'b0) begin
      failures++; $display("FAIL err_pre got ren=%b err=%b exp ren=0111 err=0", x_fifo_ren, err);
    end
    tick();
    x_fifo_empty = 4'b0000;
    #1;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
    repeat (12) tick();
    checks++;
    if (out_val !== 1'b1 || err !== 1'b1) begin
      failures++; $display("FAIL k15_out_start got val=%b err=%b exp val=1 err=1", out_val, err);
    end
    cfg_k = 4'd3; out_rdy = 1'b1;
    repeat (4) tick();
    out_rdy = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || x_send_rdy !== 1'b1) begin
      failures++; $display("FAIL err_sticky got err=%b rdy=%b exp err=1 rdy=1", err, x_send_rdy);
    end
    $display("k15 job done, err held");
  endtask

  task automatic test_reset_flush;
    logic [23:0] v;
    x_send_val = 1'b1; w_send_val = 1'b1;
    repeat (3) tick();
    x_send_val = 1'b0; w_send_val = 1'b0;
    repeat (7) tick();
    #1;
    checks++;
    if (mac_en !== 1'b1 || x_fifo_ren !== 4'b0000) begin
      failures++; $display("FAIL rf_in_flush got mac=%b ren=%b exp mac=1 ren=0000", mac_en, x_fifo_ren);
    end
    rst = 1'b0; x_send_val = 1'b1; out_rdy = 1'b1;
    #1;
    v = {x_send_rdy, w_send_rdy, x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren,
         mac_en, acc_clr, out_val, out_row, err};
    checks++;
    if (v !== 24'd0) begin failures++; $display("FAIL rf_rst_low got=%h exp=%h", v, 24'd0); end
    tick();
    v = {x_send_rdy, w_send_rdy, x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren,
         mac_en, acc_clr, out_val, out_row, err};
    checks++;
    if (v !== 24'd0) begin failures++; $display("FAIL rf_rst_edge got=%h exp=%h", v, 24'd0); end
    rst = 1'b1; x_send_val = 1'b0; out_rdy = 1'b0;
    #1;
    checks++;
    if ({x_send_rdy, err, mac_en, out_val} !== 4'b1000) begin
      failures++; $display("FAIL rf_release got=%b exp=1000", {x_send_rdy, err, mac_en, out_val});
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    checks++;
    if (perf_cycles !== 32'd0 || job_cnt !== 16'd0) begin
      failures++; $display("FAIL rf_perf got cyc=%0d jobs=%0d exp 0 0", perf_cycles, job_cnt);
    end
`endif
    $display("reset during flush recovered");
  endtask

  initial begin
    rst = 1'b0; cfg_k = 4'd3;
    x_send_val = 1'b0; w_send_val = 1'b0; out_rdy = 1'b0;
    x_fifo_full = 4'd0; x_fifo_empty = 4'd0; w_fifo_full = 4'd0; w_fifo_empty = 4'd0;
    test_reset();
    test_basic_k3();
    test_uneven_k2();
    test_backpressure();
    test_k0();
    test_k15_clamp_err();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
